// File: rtl/data_io_pkg.sv
// Shared definitions for the data_io sequencer: FSM state encoding,
// data_io word parity codes, word field positions and a word builder.
package data_io_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LSB  = 3'd1,
        ST_MSB  = 3'd2,
        ST_REST = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } seq_state_e;

    // Parity codes: consecutive writes always carry a different code,
    // so data_io recognises each one as a new word.
    localparam logic [1:0] PAR_LSB  = 2'b11;
    localparam logic [1:0] PAR_MSB  = 2'b10;
    localparam logic [1:0] PAR_IDLE = 2'b00;

    // data_io_in word layout
    localparam int WORD_W = 16;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 14;
    localparam int RSV_HI = 13;
    localparam int RSV_LO = 12;
    localparam int PAR_HI = 11;
    localparam int PAR_LO = 10;
    localparam int PAY_HI = 9;
    localparam int PAY_LO = 0;

    // Command / response widths and data_io_out field positions
    localparam int OPERAND_W = 19;
    localparam int RESULT_W  = 7;
    localparam int STATUS_W  = 2;
    localparam int RES_HI    = 6;
    localparam int RES_LO    = 0;
    localparam int STS_HI    = 8;
    localparam int STS_LO    = 7;

    // Assemble one data_io_in word from its fields; reserved bits stay zero
    function automatic logic [WORD_W-1:0] build_word(
        input logic [1:0] opc,
        input logic [1:0] par,
        input logic [9:0] payload
    );
        logic [WORD_W-1:0] w;
        w                = 16'h0000;
        w[OPC_HI:OPC_LO] = opc;
        w[RSV_HI:RSV_LO] = 2'b00;
        w[PAR_HI:PAR_LO] = par;
        w[PAY_HI:PAY_LO] = payload;
        return w;
    endfunction

endpackage

// File: rtl/data_io_sequencer.sv
// data_io_sequencer: takes one command at a time, writes it to a data_io
// block as LSB / MSB / REST words, waits RESULT_WAIT cycles, captures the
// response and holds it until the requester accepts it.
// Optional feature macro: DATA_IO_SEQ_SKIP_LSB_EN -- skip the LSB write when
// the low operand half equals the value data_io already holds.
module data_io_sequencer
    import data_io_pkg::*;
#(
    parameter int unsigned RESULT_WAIT = 32'd4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_opcode,
    input  logic [OPERAND_W-1:0] cmd_operand,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RESULT_W-1:0]  rsp_result,
    output logic [STATUS_W-1:0]  rsp_status,
    output logic [WORD_W-1:0]    io_data_in,
    input  logic [WORD_W-1:0]    io_data_out,
    output logic                 busy
);

    localparam logic [7:0] WAIT_INIT = 8'(RESULT_WAIT);

    seq_state_e                 state_r;
    seq_state_e                 next_state_s;
    logic [1:0]                 opcode_r;
    logic [OPERAND_W-1:0]       operand_r;
    logic [1:0]                 opc_sel_s;
    logic [OPERAND_W-1:0]       opd_sel_s;
    logic [7:0]                 cnt_r;
    logic                       wait_last_s;
    logic                       accept_s;
    logic                       sample_s;
    logic                       skip_lsb_s;
    logic [WORD_W-1:0]          io_word_s;
    logic [WORD_W-1:0]          io_data_in_r;
    logic                       busy_r;
    logic                       cmd_ready_r;
    logic                       rsp_valid_r;
    logic [RESULT_W-1:0]        rsp_result_r;
    logic [STATUS_W-1:0]        rsp_status_r;
    logic                       io_hi_unused_s;

    // Upper data_io_out bits carry no information
    assign io_hi_unused_s = ^io_data_out[WORD_W-1:STS_HI+1];

    assign accept_s    = (state_r == ST_IDLE) && cmd_valid;
    assign wait_last_s = (cnt_r <= 8'd1);
    assign sample_s    = (state_r == ST_WAIT) && wait_last_s;

`ifdef DATA_IO_SEQ_SKIP_LSB_EN
    logic [PAY_HI:PAY_LO] last_lsb_r;
    logic                 lsb_known_r;

    // Track the low half held in data_io; its accumulator clears on the same reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_lsb_r  <= 10'h000;
            lsb_known_r <= 1'b1;
        end else if (state_r == ST_LSB) begin
            last_lsb_r  <= operand_r[PAY_HI:PAY_LO];
            lsb_known_r <= 1'b1;
        end else begin
            last_lsb_r  <= last_lsb_r;
            lsb_known_r <= lsb_known_r;
        end
    end

    assign skip_lsb_s = lsb_known_r && (cmd_operand[PAY_HI:PAY_LO] == last_lsb_r);
`else
    assign skip_lsb_s = 1'b0;
`endif

    // While idle the word being built comes from the live command inputs
    always_comb begin
        opc_sel_s = opcode_r;
        opd_sel_s = operand_r;
        if (state_r == ST_IDLE) begin
            opc_sel_s = cmd_opcode;
            opd_sel_s = cmd_operand;
        end else begin
            opc_sel_s = opcode_r;
            opd_sel_s = operand_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (skip_lsb_s) begin
                        next_state_s = ST_MSB;
                    end else begin
                        next_state_s = ST_LSB;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LSB:  next_state_s = ST_MSB;
            ST_MSB:  next_state_s = ST_REST;
            ST_REST: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: the word data_io sees during the upcoming state
    always_comb begin
        io_word_s = 16'h0000;
        case (next_state_s)
            ST_IDLE: io_word_s = 16'h0000;
            ST_LSB:  io_word_s = build_word(2'b00, PAR_LSB, opd_sel_s[PAY_HI:PAY_LO]);
            ST_MSB:  io_word_s = build_word(opc_sel_s, PAR_MSB,
                                            {1'b0, opd_sel_s[OPERAND_W-1:PAY_HI+1]});
            ST_REST: io_word_s = build_word(opc_sel_s, PAR_IDLE, 10'h000);
            ST_WAIT: io_word_s = build_word(opc_sel_s, PAR_IDLE, 10'h000);
            ST_DONE: io_word_s = 16'h0000;
            default: io_word_s = 16'h0000;
        endcase
    end

    // Capture the accepted command for the rest of the sequence
    always_ff @(posedge clk) begin
        if (!rstn) begin
            opcode_r  <= 2'b00;
            operand_r <= 19'h0_0000;
        end else if (accept_s) begin
            opcode_r  <= cmd_opcode;
            operand_r <= cmd_operand;
        end else begin
            opcode_r  <= opcode_r;
            operand_r <= operand_r;
        end
    end

    // Result wait counter: loaded in REST, counts down through WAIT
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r <= 8'd0;
        end else if (state_r == ST_REST) begin
            cnt_r <= WAIT_INIT;
        end else if ((state_r == ST_WAIT) && (cnt_r != 8'd0)) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sample the data_io response in the last WAIT cycle and hold it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_result_r <= 7'h00;
            rsp_status_r <= 2'b00;
        end else if (sample_s) begin
            rsp_result_r <= io_data_out[RES_HI:RES_LO];
            rsp_status_r <= io_data_out[STS_HI:STS_LO];
        end else begin
            rsp_result_r <= rsp_result_r;
            rsp_status_r <= rsp_status_r;
        end
    end

    // Registered handshake, status and data_io word outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            io_data_in_r <= 16'h0000;
            busy_r       <= 1'b0;
            cmd_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
        end else begin
            io_data_in_r <= io_word_s;
            busy_r       <= (next_state_s != ST_IDLE);
            cmd_ready_r  <= (next_state_s == ST_IDLE);
            rsp_valid_r  <= (next_state_s == ST_DONE);
        end
    end

    assign io_data_in = io_data_in_r;
    assign busy       = busy_r;
    assign cmd_ready  = cmd_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_status = rsp_status_r;

endmodule

// File: tb/tb_data_io_sequencer.sv
// Bench for data_io_sequencer: two instances (RESULT_WAIT=4 and =1) driven by
// directed and random commands, compared cycle by cycle with a reference
// model built from the word format and latency rules.
module tb_data_io_sequencer;

    localparam int RW0 = 4;
    localparam int RW1 = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid0, cmd_valid1;
    logic [1:0]  cmd_opcode;
    logic [18:0] cmd_operand;
    logic        rsp_ready;
    logic [15:0] io_data_out;

    logic        cmd_ready0, cmd_ready1, rsp_valid0, rsp_valid1, busy0, busy1;
    logic [6:0]  rsp_result0, rsp_result1;
    logic [1:0]  rsp_status0, rsp_status1;
    logic [15:0] io_data_in0, io_data_in1;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    int m_last [2];
    bit m_known[2];

    logic        o_ready, o_valid, o_busy;
    logic [6:0]  o_result;
    logic [1:0]  o_status;
    logic [15:0] o_word;

    assign o_ready  = (sel == 1) ? cmd_ready1  : cmd_ready0;
    assign o_valid  = (sel == 1) ? rsp_valid1  : rsp_valid0;
    assign o_busy   = (sel == 1) ? busy1       : busy0;
    assign o_result = (sel == 1) ? rsp_result1 : rsp_result0;
    assign o_status = (sel == 1) ? rsp_status1 : rsp_status0;
    assign o_word   = (sel == 1) ? io_data_in1 : io_data_in0;

    always #5 clk = ~clk;

    data_io_sequencer #(.RESULT_WAIT(RW0)) dut0 (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand), .rsp_valid(rsp_valid0),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result0), .rsp_status(rsp_status0),
        .io_data_in(io_data_in0), .io_data_out(io_data_out), .busy(busy0)
    );

    data_io_sequencer #(.RESULT_WAIT(RW1)) dut1 (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result1), .rsp_status(rsp_status1),
        .io_data_in(io_data_in1), .io_data_out(io_data_out), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic set_valid(input int id, input logic v);
        if (id == 1) cmd_valid1 = v;
        else         cmd_valid0 = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last[i]  = 0;
            m_known[i] = 1'b1;
        end
    endtask

    // One full transaction on instance id, checked every cycle
    task automatic run_txn(input int id, input logic [1:0] opc, input logic [18:0] op,
                           input logic [15:0] rdata, input int hold, input bit keep_valid);
        logic [15:0] exp_q[$];
        int lo, hi, oc, rw, n;
        bit skip;
        lo = int'(op) % 1024;
        hi = int'(op) / 1024;
        oc = int'(opc);
        rw = (id == 1) ? RW1 : RW0;
        skip = 1'b0;
`ifdef DATA_IO_SEQ_SKIP_LSB_EN
        skip = m_known[id] && (lo == m_last[id]);
`endif
        if (!skip) begin
            exp_q.push_back(16'(3 * 1024 + lo));
            m_last[id] = lo;
        end
        exp_q.push_back(16'(oc * 16384 + 2 * 1024 + hi));
        for (int i = 0; i <= rw; i++) exp_q.push_back(16'(oc * 16384));
        n = exp_q.size();

        sel = id;
        @(negedge clk);
        cmd_opcode  = opc;
        cmd_operand = op;
        set_valid(id, 1'b1);
        rsp_ready   = 1'($urandom_range(0, 1));
        io_data_out = 16'($urandom);
        chk("ready_at_accept", o_ready, 1);
        chk("idle_word", o_word, 0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (!keep_valid) begin
                set_valid(id, 1'b0);
                cmd_operand = 19'($urandom);
                cmd_opcode  = 2'($urandom);
            end
            io_data_out = (k == n) ? rdata : 16'($urandom);
            rsp_ready   = 1'($urandom_range(0, 1));
            chk($sformatf("word[%0d]", k), o_word, exp_q[k-1]);
            chk($sformatf("busy[%0d]", k), o_busy, 1);
            chk($sformatf("ready_low[%0d]", k), o_ready, 0);
            chk($sformatf("valid_early[%0d]", k), o_valid, 0);
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            io_data_out = 16'($urandom);
            chk($sformatf("rsp_valid[%0d]", h), o_valid, 1);
            chk($sformatf("rsp_result[%0d]", h), o_result, int'(rdata) % 128);
            chk($sformatf("rsp_status[%0d]", h), o_status, (int'(rdata) / 128) % 4);
            chk($sformatf("done_word[%0d]", h), o_word, 0);
            chk($sformatf("done_busy[%0d]", h), o_busy, 1);
            chk($sformatf("done_ready[%0d]", h), o_ready, 0);
            rsp_ready = (h == hold);
            if (h == hold) set_valid(id, 1'b0);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_valid", o_valid, 0);
        chk("post_ready", o_ready, 1);
        chk("post_busy", o_busy, 0);
        chk("post_word", o_word, 0);
    endtask

    initial begin
        logic [18:0] op;
        int id;
        rstn = 1'b0; cmd_valid0 = 1'b0; cmd_valid1 = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = 2'b00; cmd_operand = 19'h0; io_data_out = 16'h0000;
        model_reset();

        // reset values on both instances
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            chk("rst_word", o_word, 0);
            chk("rst_valid", o_valid, 0);
            chk("rst_result", o_result, 0);
            chk("rst_status", o_status, 0);
            chk("rst_busy", o_busy, 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            chk("rst_ready", o_ready, 1);
        end

        // low half zero right after reset, then repeat, then change, then repeat
        run_txn(0, 2'd1, {9'h0AB, 10'h000}, 16'h0123, 0, 1'b0);
        run_txn(0, 2'd1, {9'h0AB, 10'h000}, 16'h00FF, 1, 1'b0);
        run_txn(0, 2'd3, {9'h1C0, 10'h155}, 16'h0180, 0, 1'b0);
        run_txn(0, 2'd0, {9'h003, 10'h155}, 16'h0041, 0, 1'b0);

        // directed vector: expect 0x0E5A, 0x8916, 0x8000 from the word format
        run_txn(0, 2'd2, 19'h4_5A5A, 16'h0042, 0, 1'b0);
        // status 11 / result 45 held while rsp_ready stays low for 5 cycles
        run_txn(0, 2'd3, 19'h2_1234, 16'h01C5, 5, 1'b0);
        // cmd_valid held through the whole transaction
        run_txn(0, 2'd1, 19'h7_0F0F, 16'h0099, 2, 1'b1);
        // single WAIT cycle
        run_txn(1, 2'd2, 19'h0_0321, 16'h0155, 0, 1'b0);
        run_txn(1, 2'd1, 19'h5_5555, 16'h00AA, 3, 1'b1);

        // random commands on both instances
        for (int r = 0; r < 16; r++) begin
            id = int'($urandom_range(0, 1));
            op = 19'($urandom);
            if ($urandom_range(0, 3) == 0) op[9:0] = 10'(m_last[id]);
            run_txn(id, 2'($urandom), op, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // reset while the MSB word is being driven
        sel = 0;
        op = 19'($urandom);
        if ((int'(op) % 1024) == m_last[0]) op[0] = ~op[0];
        @(negedge clk);
        cmd_opcode = 2'd1; cmd_operand = op; cmd_valid0 = 1'b1;
        @(negedge clk);
        cmd_valid0 = 1'b0;
        chk("mid_lsb", o_word, 16'(3 * 1024 + int'(op) % 1024));
        @(negedge clk);
        chk("mid_msb", o_word, 16'(16384 + 2 * 1024 + int'(op) / 1024));
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        chk("mid_rst_word", o_word, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_ready", o_ready, 1);
        run_txn(0, 2'd2, 19'h1_2345, 16'h0107, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
